// File: rtl/corriente_sp_sequencer_pkg.sv
// rtl/corriente_sp_sequencer_pkg.sv - shared constants, ramp state encoding and saturating helpers
package corriente_pkg;

    localparam int W        = 10;
    localparam int MAX_SP   = 1000;
    localparam int STEP     = 50;
    localparam int RESET_SP = 500;

    typedef logic [W-1:0] sp_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    // min(v + inc, lim), summed one bit wider so it cannot wrap
    function automatic sp_t sat_up(sp_t v, sp_t inc, sp_t lim);
        logic [W:0] sum;
        sum = {1'b0, v} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[W-1:0];
    endfunction

    // max(v - dec, floor_v), compared one bit wider so v - dec never underflows
    function automatic sp_t sat_down(sp_t v, sp_t dec, sp_t floor_v);
        return ({1'b0, v} < ({1'b0, floor_v} + {1'b0, dec})) ? floor_v : v - dec;
    endfunction

endpackage

// File: rtl/corriente_sp_sequencer_if.sv
// rtl/corriente_sp_sequencer_if.sv - host setpoint write handshake
interface corriente_sp_sequencer_if;
    import corriente_pkg::*;

    logic host_req;
    sp_t  host_sp;
    logic host_ack;
    logic host_err;

    modport master (
        output host_req,
        output host_sp,
        input  host_ack,
        input  host_err
    );

    modport slave (
        input  host_req,
        input  host_sp,
        output host_ack,
        output host_err
    );

endinterface

// File: rtl/corriente_sp_sequencer_btn_debounce.sv
// rtl/corriente_sp_sequencer_btn_debounce.sv - button synchronizer, debouncer and press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk_nx,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles the synchronized input disagrees with level
    always_ff @(posedge clk_nx or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/corriente_sp_sequencer.sv
// rtl/corriente_sp_sequencer.sv - arbitrates buttons and host into a target, ramps the output toward it
module corriente_sp_sequencer
    import corriente_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int RAMP_DIV     = 1000,
    parameter int RAMP_STEP    = 10
) (
    input  logic                      clk_nx,
    input  logic                      rst,
    input  logic                      btn_up,
    input  logic                      btn_down,
    corriente_sp_sequencer_if.slave   host,
    output sp_t                       tgt_sp,
    output sp_t                       cant_corriente,
    output logic                      busy
);

    localparam int            TW        = $clog2(RAMP_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
    localparam sp_t           MAX_V     = sp_t'(MAX_SP);
    localparam sp_t           STEP_V    = sp_t'(STEP);
    localparam sp_t           RESET_V   = sp_t'(RESET_SP);
    localparam sp_t           RSTEP_V   = sp_t'(RAMP_STEP);

    logic          up_p;
    logic          dn_p;
    logic          press_any;
    logic          armed;
    logic          host_ack_q;
    logic          host_err_q;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    ramp_state_t   state;
    sp_t           up_next;
    sp_t           dn_next;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk_nx (clk_nx),
        .rst    (rst),
        .btn    (btn_up),
        .press  (up_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk_nx (clk_nx),
        .rst    (rst),
        .btn    (btn_down),
        .press  (dn_p)
    );

    assign press_any     = up_p | dn_p;
    assign host.host_ack = host_ack_q;
    assign host.host_err = host_err_q;

    // Target arbitration: presses win; a colliding host request waits for a press-free cycle
    always_ff @(posedge clk_nx or negedge rst) begin
        if (!rst) begin
            tgt_sp     <= RESET_V;
            armed      <= 1'b1;
            host_ack_q <= 1'b0;
            host_err_q <= 1'b0;
        end else begin
            host_ack_q <= 1'b0;
            host_err_q <= 1'b0;
            if (!host.host_req) begin
                armed <= 1'b1;
            end
            if (up_p && !dn_p) begin
                tgt_sp <= sat_up(tgt_sp, STEP_V, MAX_V);
            end else if (dn_p && !up_p) begin
                tgt_sp <= sat_down(tgt_sp, STEP_V, sp_t'(0));
            end else if (!press_any && host.host_req && armed) begin
                host_ack_q <= 1'b1;
                armed      <= 1'b0;
                if (host.host_sp > MAX_V) begin
                    host_err_q <= 1'b1;
                end else begin
                    tgt_sp <= host.host_sp;
                end
            end
        end
    end

    // Free-running ramp timebase, deliberately not restarted by target changes
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_nx or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign up_next = sat_up(cant_corriente, RSTEP_V, tgt_sp);
    assign dn_next = sat_down(cant_corriente, RSTEP_V, tgt_sp);

    always_ff @(posedge clk_nx or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cant_corriente <= RESET_V;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_sp > cant_corriente) begin
                        state <= RAMP_UP;
                    end else if (tgt_sp < cant_corriente) begin
                        state <= RAMP_DOWN;
                    end
                end
                RAMP_UP: begin
                    if (tgt_sp < cant_corriente) begin
                        state <= RAMP_DOWN;
                    end else if (tgt_sp == cant_corriente) begin
                        state <= IDLE;
                    end else if (tick) begin
                        cant_corriente <= up_next;
                        if (up_next == tgt_sp) begin
                            state <= IDLE;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tgt_sp > cant_corriente) begin
                        state <= RAMP_UP;
                    end else if (tgt_sp == cant_corriente) begin
                        state <= IDLE;
                    end else if (tick) begin
                        cant_corriente <= dn_next;
                        if (dn_next == tgt_sp) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_corriente_sp_sequencer.sv
// tb/tb_corriente_sp_sequencer.sv - directed table and sequence bench for corriente_sp_sequencer
module tb_corriente_sp_sequencer;
    import corriente_pkg::*;

    localparam int OP_UP   = 0;
    localparam int OP_DN   = 1;
    localparam int OP_HOST = 2;
    localparam int OP_BOTH = 3;
    localparam int NVEC    = 14;

    typedef struct {
        int op;
        int val;
        int exp_tgt;
        int exp_err;
    } vec_t;

    logic clk_nx = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_down;
    sp_t  tgt_sp;
    sp_t  cant_corriente;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;

    corriente_sp_sequencer_if hif();

    corriente_sp_sequencer #(
        .DEBOUNCE_CYC (4),
        .RAMP_DIV     (4),
        .RAMP_STEP    (10)
    ) dut (
        .clk_nx         (clk_nx),
        .rst            (rst),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .host           (hif),
        .tgt_sp         (tgt_sp),
        .cant_corriente (cant_corriente),
        .busy           (busy)
    );

    always #5 clk_nx = ~clk_nx;

    task automatic step();
        @(posedge clk_nx);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit up, input bit dn);
        btn_up   = up;
        btn_down = dn;
        repeat (8) step();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (8) step();
    endtask

    task automatic host_write(input int val, input int hold,
                              output int acks, output int errs, output int stray);
        acks  = 0;
        errs  = 0;
        stray = 0;
        hif.host_req = 1'b1;
        hif.host_sp  = sp_t'(val);
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) hif.host_req = 1'b0;
            step();
            if (hif.host_ack) acks++;
            if (hif.host_err) begin
                if (hif.host_ack) errs++;
                else stray++;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int exp);
        int k;
        k = 0;
        while (!(int'(cant_corriente) == exp && !busy) && k < 400) begin
            step();
            k++;
        end
        check({name, "_cant"}, cant_corriente, exp);
        check({name, "_busy"}, busy, 0);
    endtask

    // Ramp invariant: each edge moves the output at most one step, toward the old target, within MAX_SP
    bit mon_valid = 1'b0;
    int prev_cant;
    int prev_tgt;
    int m_lo;
    int m_hi;
    int m_d;
    always @(posedge clk_nx) begin
        #1;
        if (!rst) begin
            mon_valid = 1'b0;
        end else begin
            if (mon_valid) begin
                m_lo = (prev_cant < prev_tgt) ? prev_cant : prev_tgt;
                m_hi = (prev_cant > prev_tgt) ? prev_cant : prev_tgt;
                m_d  = int'(cant_corriente) - prev_cant;
                if (m_d < 0) m_d = -m_d;
                n_chk++;
                if (cant_corriente > MAX_SP || cant_corriente < m_lo || cant_corriente > m_hi || m_d > 10) begin
                    n_fail++;
                    $display("FAIL ramp_bound: got cant=%0d, expected within [%0d,%0d] step<=10", cant_corriente, m_lo, m_hi);
                end
            end
            prev_cant = cant_corriente;
            prev_tgt  = tgt_sp;
            mon_valid = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl [NVEC];
        int acks;
        int errs;
        int stray;
        int last;
        int last_t;
        int done;
        int k;
        int mx;

        tbl[0]  = '{OP_HOST, 950,  950,  0};
        tbl[1]  = '{OP_UP,   0,    1000, 0};
        tbl[2]  = '{OP_UP,   0,    1000, 0};
        tbl[3]  = '{OP_UP,   0,    1000, 0};
        tbl[4]  = '{OP_HOST, 30,   30,   0};
        tbl[5]  = '{OP_DN,   0,    0,    0};
        tbl[6]  = '{OP_DN,   0,    0,    0};
        tbl[7]  = '{OP_HOST, 1023, 0,    1};
        tbl[8]  = '{OP_HOST, 1000, 1000, 0};
        tbl[9]  = '{OP_HOST, 1001, 1000, 1};
        tbl[10] = '{OP_BOTH, 0,    1000, 0};
        tbl[11] = '{OP_DN,   0,    950,  0};
        tbl[12] = '{OP_HOST, 0,    0,    0};
        tbl[13] = '{OP_UP,   0,    50,   0};

        rst          = 1'b0;
        btn_up       = 1'b0;
        btn_down     = 1'b0;
        hif.host_req = 1'b0;
        hif.host_sp  = '0;
        repeat (3) step();
        check("reset_tgt", tgt_sp, 500);
        check("reset_cant", cant_corriente, 500);
        check("reset_busy", busy, 0);
        check("reset_ack", hif.host_ack, 0);
        check("reset_err", hif.host_err, 0);
        rst = 1'b1;
        repeat (2) step();

        // Up press: target moves on the 7th edge after the raw edge, output ramps 10 per 4 cycles
        btn_up = 1'b1;
        repeat (6) step();
        check("up_lat_before", tgt_sp, 500);
        step();
        check("up_lat_at7", tgt_sp, 550);
        last   = 500;
        last_t = -1;
        done   = 0;
        for (int t = 0; t < 40 && done == 0; t++) begin
            if (t == 1) btn_up = 1'b0;
            step();
            if (int'(cant_corriente) != last) begin
                check("ramp_up_step", cant_corriente, last + 10);
                if (last_t >= 0) check("ramp_up_spacing", t - last_t, 4);
                check("ramp_up_busy", busy, (cant_corriente == 550) ? 0 : 1);
                last   = cant_corriente;
                last_t = t;
                if (cant_corriente == 550) done = 1;
            end
        end
        check("ramp_up_done", done, 1);
        repeat (10) step();

        // Glitch shorter than the debounce window
        btn_up = 1'b1;
        repeat (3) step();
        btn_up = 1'b0;
        repeat (12) step();
        check("glitch_tgt", tgt_sp, 550);
        check("glitch_busy", busy, 0);

        // Host write held several cycles: single ack, ramp down
        host_write(200, 5, acks, errs, stray);
        check("host200_acks", acks, 1);
        check("host200_err", errs, 0);
        check("host200_tgt", tgt_sp, 200);
        wait_idle("host200", 200);

        // Press and host request collide: press first, host on the next cycle
        btn_up = 1'b1;
        repeat (6) step();
        hif.host_req = 1'b1;
        hif.host_sp  = sp_t'(300);
        step();
        check("coll_press_tgt", tgt_sp, 250);
        check("coll_press_noack", hif.host_ack, 0);
        step();
        check("coll_host_tgt", tgt_sp, 300);
        check("coll_host_ack", hif.host_ack, 1);
        step();
        check("coll_no_reack", hif.host_ack, 0);
        btn_up       = 1'b0;
        hif.host_req = 1'b0;
        repeat (10) step();
        check("coll_tgt_hold", tgt_sp, 300);
        wait_idle("coll", 300);

        // Mid-ramp reversal
        host_write(600, 3, acks, errs, stray);
        check("rev600_acks", acks, 1);
        k = 0;
        while (cant_corriente != 520 && k < 300) begin
            step();
            k++;
        end
        check("rev_reach520", cant_corriente, 520);
        hif.host_req = 1'b1;
        hif.host_sp  = sp_t'(400);
        step();
        check("rev_ack", hif.host_ack, 1);
        check("rev_tgt", tgt_sp, 400);
        hif.host_req = 1'b0;
        mx = cant_corriente;
        k  = 0;
        while (!(cant_corriente == 400 && !busy) && k < 300) begin
            step();
            if (int'(cant_corriente) > mx) mx = cant_corriente;
            k++;
        end
        check("rev_peak_le530", (mx <= 530) ? 1 : 0, 1);
        check("rev_final_cant", cant_corriente, 400);
        check("rev_final_busy", busy, 0);

        // Asynchronous reset in the middle of a ramp
        host_write(900, 2, acks, errs, stray);
        repeat (20) step();
        check("rst_pre_busy", busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check("rst_async_tgt", tgt_sp, 500);
        check("rst_async_cant", cant_corriente, 500);
        check("rst_async_busy", busy, 0);
        check("rst_async_ack", hif.host_ack, 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_after_tgt", tgt_sp, 500);
        check("rst_after_busy", busy, 0);

        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].op == OP_HOST) begin
                host_write(tbl[i].val, 5, acks, errs, stray);
                check($sformatf("vec%0d_acks", i), acks, 1);
                check($sformatf("vec%0d_err", i), errs, tbl[i].exp_err);
                check($sformatf("vec%0d_stray_err", i), stray, 0);
            end else begin
                press(tbl[i].op == OP_UP || tbl[i].op == OP_BOTH,
                      tbl[i].op == OP_DN || tbl[i].op == OP_BOTH);
            end
            check($sformatf("vec%0d_tgt", i), tgt_sp, tbl[i].exp_tgt);
        end
        wait_idle("final", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
